// File: rtl/mem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package mem_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Bytes per stored word; the low address bits must be zero
    localparam int WORD_BYTES = 4;

    // Width of the wait-state counter (WAIT range 0..15)
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage: combinational read, synchronous write, no reset on contents.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Commit a store into the addressed word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store target with programmable wait states,
// back-pressure on the response, and misaligned/out-of-range error reporting.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                OFS_W   = $clog2(WORD_BYTES);
    localparam logic [WAIT_W-1:0] LP_WAIT = WAIT_W'(WAIT);

    state_t            r_state;
    state_t            w_state_nx;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_write;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_commit;
    logic              w_sel_write;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [31:0]       w_idx;
    logic              w_err;
    logic              w_we;
    logic [31:0]       w_mem_rdata;

    // State register; reset abandons any in-flight request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nx = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = (WAIT == 0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == WAIT_W'(1)) begin
                    w_state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= LP_WAIT;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture the request so the requester may drop it after acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // With zero wait states the commit edge is the accept edge itself,
    // so the live request is used instead of the (not yet loaded) latches.
    assign w_sel_write = (r_state == IDLE) ? req_write : r_write;
    assign w_sel_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_sel_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    // Full 30-bit word index compared against DEPTH: no aliasing
    assign w_idx    = w_sel_addr >> OFS_W;
    assign w_err    = (w_sel_addr[OFS_W-1:0] != '0) || (w_idx >= 32'(DEPTH));
    assign w_commit = (r_state != RESP) && (w_state_nx == RESP);
    assign w_we     = reset && w_commit && w_sel_write && !w_err;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_idx[AW-1:0]),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Response payload: set at commit, cleared once the response is taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_sel_write) ? '0 : w_mem_rdata;
        end else if (resp_valid && resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one WAIT=2 instance and one WAIT=0 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        tx_valid;
    logic        tx_write;
    logic        tx_rready;
    logic [31:0] tx_addr;
    logic [31:0] tx_wdata;

    logic        a_req_valid, a_req_ready, a_resp_valid, a_err;
    logic [31:0] a_rdata;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_err;
    logic [31:0] b_rdata;

    logic        m_req_ready, m_resp_valid, m_err;
    logic [31:0] m_rdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign a_req_valid  = tx_valid & ~sel;
    assign b_req_valid  = tx_valid & sel;
    assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign m_rdata      = sel ? b_rdata      : a_rdata;
    assign m_err        = sel ? b_err        : a_err;

    mem_responder #(.DEPTH(1024), .WAIT(2)) u_dut_a (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (tx_write),
        .req_addr   (tx_addr),
        .req_wdata  (tx_wdata),
        .resp_valid (a_resp_valid),
        .resp_ready (tx_rready),
        .resp_rdata (a_rdata),
        .resp_err   (a_err)
    );

    mem_responder #(.DEPTH(16), .WAIT(0)) u_dut_b (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (tx_write),
        .req_addr   (tx_addr),
        .req_wdata  (tx_wdata),
        .resp_valid (b_resp_valid),
        .resp_ready (tx_rready),
        .resp_rdata (b_rdata),
        .resp_err   (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request/response; entered just after a rising edge with the selected DUT idle.
    // lat counts cycles from the accept cycle to the first cycle showing resp_valid.
    task automatic xact(input string tag, input logic w, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
        tx_write  = w;
        tx_addr   = addr;
        tx_wdata  = wdata;
        tx_valid  = 1'b1;
        tx_rready = (hold == 0);
        chk({tag, "/ready"}, 32'(m_req_ready), 32'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_addr  = 32'hFFFF_FFF0;
        tx_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!m_resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!m_resp_valid) chk({tag, "/timeout"}, 32'd0, 32'd1);
        rdata = m_rdata;
        err   = m_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_vr"}, {30'd0, m_resp_valid, m_req_ready}, 32'h2);
            chk({tag, "/hold_rd"}, m_rdata, rdata);
            chk({tag, "/hold_er"}, 32'(m_err), 32'(err));
        end
        tx_rready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "/idle"}, {30'd0, m_req_ready, m_resp_valid}, 32'h2);
        chk({tag, "/clr"}, m_rdata | {31'd0, m_err}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    int          nresp;
    logic [31:0] got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel       = 1'b0;
        tx_valid  = 1'b0;
        tx_write  = 1'b0;
        tx_rready = 1'b1;
        tx_addr   = '0;
        tx_wdata  = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/a_ready", 32'(a_req_ready), 32'd1);
        chk("rst/a_outs", {30'd0, a_resp_valid, a_err} | a_rdata, 32'd0);
        chk("rst/b_ready", 32'(b_req_ready), 32'd1);
        chk("rst/b_outs", {30'd0, b_resp_valid, b_err} | b_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store then load, WAIT=2
        xact("st4036", 1'b1, 32'd4036, 32'd1024, 0, rd, er, lt);
        chk("st4036/lat", 32'(lt), 32'd3);
        chk("st4036/err", 32'(er), 32'd0);
        chk("st4036/rd", rd, 32'd0);
        xact("ld4036", 1'b0, 32'd4036, 32'd0, 0, rd, er, lt);
        chk("ld4036/lat", 32'(lt), 32'd3);
        chk("ld4036/rd", rd, 32'd1024);
        chk("ld4036/err", 32'(er), 32'd0);

        // Back-pressure on a load of 7
        xact("st0", 1'b1, 32'd0, 32'd7, 0, rd, er, lt);
        xact("ld0bp", 1'b0, 32'd0, 32'd0, 5, rd, er, lt);
        chk("ld0bp/rd", rd, 32'd7);
        chk("ld0bp/err", 32'(er), 32'd0);

        // Error responses
        xact("mis", 1'b1, 32'd4038, 32'd5, 0, rd, er, lt);
        chk("mis/err", 32'(er), 32'd1);
        chk("mis/rd", rd, 32'd0);
        xact("oor", 1'b1, 32'd4096, 32'd5, 0, rd, er, lt);
        chk("oor/err", 32'(er), 32'd1);
        xact("oorld", 1'b0, 32'd4096, 32'd0, 0, rd, er, lt);
        chk("oorld/err", 32'(er), 32'd1);
        chk("oorld/rd", rd, 32'd0);
        xact("ld4036b", 1'b0, 32'd4036, 32'd0, 0, rd, er, lt);
        chk("ld4036b/rd", rd, 32'd1024);
        chk("ld4036b/err", 32'(er), 32'd0);

        // Last valid word
        xact("st4092", 1'b1, 32'd4092, 32'h0000_1234, 0, rd, er, lt);
        chk("st4092/err", 32'(er), 32'd0);
        xact("ld4092", 1'b0, 32'd4092, 32'd0, 0, rd, er, lt);
        chk("ld4092/rd", rd, 32'h0000_1234);

        // Request inputs ignored while busy
        tx_write = 1'b0; tx_addr = 32'd4036; tx_valid = 1'b1; tx_rready = 1'b1;
        @(posedge clk); #1;
        tx_write = 1'b1; tx_addr = 32'd0; tx_wdata = 32'hBAD0_BAD0;
        chk("ign/busy", 32'(m_req_ready), 32'd0);
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_addr = 32'd8;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        nresp = 0;
        got   = '0;
        for (int i = 0; i < 10; i++) begin
            if (m_resp_valid) begin
                nresp++;
                got = m_rdata;
            end
            @(posedge clk); #1;
        end
        chk("ign/count", 32'(nresp), 32'd1);
        chk("ign/rd", got, 32'd1024);
        xact("ign/ld0", 1'b0, 32'd0, 32'd0, 0, rd, er, lt);
        chk("ign/ld0rd", rd, 32'd7);

        // Asynchronous reset while a store is pending
        xact("st16", 1'b1, 32'd16, 32'd55, 0, rd, er, lt);
        tx_write = 1'b1; tx_addr = 32'd16; tx_wdata = 32'd99; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("arst/busy", 32'(m_req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst/ready", 32'(m_req_ready), 32'd1);
        chk("arst/outs", {30'd0, m_resp_valid, m_err} | m_rdata, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst/after", {30'd0, m_req_ready, m_resp_valid}, 32'h2);
        xact("ld16", 1'b0, 32'd16, 32'd0, 0, rd, er, lt);
        chk("ld16/rd", rd, 32'd55);

        // Zero wait-state instance
        sel = 1'b1;
        @(posedge clk); #1;
        xact("b/st8", 1'b1, 32'd8, 32'hDEAD_BEEF, 0, rd, er, lt);
        chk("b/st8lat", 32'(lt), 32'd1);
        chk("b/st8err", 32'(er), 32'd0);
        xact("b/ld8", 1'b0, 32'd8, 32'd0, 0, rd, er, lt);
        chk("b/ld8lat", 32'(lt), 32'd1);
        chk("b/ld8rd", rd, 32'hDEAD_BEEF);
        xact("b/oor", 1'b0, 32'd64, 32'd0, 0, rd, er, lt);
        chk("b/oorerr", 32'(er), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
